// File: rtl/key_debounce_if.sv
// Key bundle between the raw DE2 buttons and the debounced outputs.
// master drives key_n (board/bench side); slave is the debouncer.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer + debounce FSM producing a clean level and press/release pulses.
// Optional auto-repeat of key_press while held: define KEY_DEBOUNCE_REPEAT_EN.
module key_debounce #(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned REPEAT_W      = 26
) (
  input  logic           clk,
  input  logic           reset_n,
  key_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_rep_hit;

    // Two-flop synchronizer; idles at the released level.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1 <= 1'b1;
        r_s2 <= 1'b1;
      end else begin
        r_s1 <= bus.key_n[g];
        r_s2 <= r_s1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    // Next state: a level change is accepted only after it holds for STABLE_CYCLES+1 samples.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_s2) w_state_nxt = S_PRESS_WAIT;
        end
        S_PRESS_WAIT: begin
          if (r_s2) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_PRESSED;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_PRESSED: begin
          if (r_s2) begin
            w_state_nxt = S_RELEASE_WAIT;
          end else begin
            w_press_nxt = w_rep_hit;
          end
        end
        S_RELEASE_WAIT: begin
          if (!r_s2) begin
            w_state_nxt = S_PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt   = S_IDLE;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      // Counter restarts from zero on every state entry, so it never wraps.
      if (w_state_nxt != r_state) w_cnt_nxt = '0;

      w_level_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_WAIT);
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [REPEAT_W-1:0] REP_DELAY_LAST  = REPEAT_W'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_W-1:0] REP_PERIOD_LAST = REPEAT_W'(REPEAT_PERIOD - 1);

    logic [REPEAT_W-1:0] r_rep_cnt;
    logic                r_rep_armed;
    logic                w_rep_run;

    // Repeat timer only advances while the key sits in PRESSED and stays there.
    assign w_rep_run = (r_state == S_PRESSED) && !r_s2;
    assign w_rep_hit = w_rep_run &&
                       (r_rep_cnt == (r_rep_armed ? REP_PERIOD_LAST : REP_DELAY_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end else if (!w_rep_run) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end else if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + REPEAT_W'(1);
      end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    assign w_level[g]   = r_level;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
  end

`ifndef KEY_DEBOUNCE_REPEAT_EN
  // Repeat parameters have no effect in this build.
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), 32'(REPEAT_W)};
`endif

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce against a run-length reference model.
// Honours KEY_DEBOUNCE_REPEAT_EN the same way the design does.
module tb_key_debounce;

  localparam int unsigned N         = 4;
  localparam int unsigned STABLE    = 8;
  localparam int unsigned CW        = 4;
  localparam int unsigned REP_DELAY = 20;
  localparam int unsigned REP_PER   = 6;
  localparam int unsigned REP_W     = 6;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(N)) bus ();

  key_debounce #(
    .N_KEYS(N), .STABLE_CYCLES(STABLE), .CNT_W(CW),
    .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PER), .REPEAT_W(REP_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the key as seen two samples late; a change is accepted after STABLE+1
  // consecutive opposing observations; repeats counted from acceptance with plain arithmetic.
  logic          m_lvl  [N];
  int            m_run  [N];
  int            m_hold [N];
  logic          m_h1   [N];
  logic          m_h2   [N];
  logic [N-1:0]  exp_level, exp_press, exp_release;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0;
      m_h1[i] = 1'b1;  m_h2[i] = 1'b1;
    end
    exp_level = '0; exp_press = '0; exp_release = '0;
  endtask

  task automatic model_step(input logic [N-1:0] kn);
    logic p;
    for (int i = 0; i < N; i++) begin
      p = !m_h2[i];
      m_h2[i] = m_h1[i];
      m_h1[i] = kn[i];
      exp_press[i]   = 1'b0;
      exp_release[i] = 1'b0;
      if (p != m_lvl[i]) begin
        m_run[i]++;
        m_hold[i] = 0;
        if (m_run[i] == int'(STABLE) + 1) begin
          m_lvl[i] = p;
          m_run[i] = 0;
          if (p) exp_press[i] = 1'b1;
          else   exp_release[i] = 1'b1;
        end
      end else if (m_run[i] != 0) begin
        m_run[i]  = 0;
        m_hold[i] = 0;
      end else if (m_lvl[i]) begin
        m_hold[i]++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        if (m_hold[i] >= int'(REP_DELAY) && ((m_hold[i] - int'(REP_DELAY)) % int'(REP_PER)) == 0)
          exp_press[i] = 1'b1;
`endif
      end
      exp_level[i] = m_lvl[i];
    end
  endtask

  // Observations of the DUT, relative to the last clear_obs().
  int edge_no;
  int press_cnt   [N];
  int release_cnt [N];
  int level_cnt   [N];
  int first_press [N];
  int first_rel   [N];
  int q_press0[$];

  task automatic clear_obs();
    edge_no = 0;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; level_cnt[i] = 0;
      first_press[i] = 0; first_rel[i] = 0;
    end
    q_press0.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.key_n);
    edge_no++;
    @(negedge clk);
    check("key_level",   32'(bus.key_level),   32'(exp_level));
    check("key_press",   32'(bus.key_press),   32'(exp_press));
    check("key_release", 32'(bus.key_release), 32'(exp_release));
    for (int i = 0; i < N; i++) begin
      if (bus.key_press[i]) begin
        press_cnt[i]++;
        if (first_press[i] == 0) first_press[i] = edge_no;
        if (i == 0) q_press0.push_back(edge_no);
      end
      if (bus.key_release[i]) begin
        release_cnt[i]++;
        if (first_rel[i] == 0) first_rel[i] = edge_no;
      end
      if (bus.key_level[i]) level_cnt[i]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_reset(input int cycles);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_level",   32'(bus.key_level),   32'(exp_level));
    check("rst_press",   32'(bus.key_press),   32'(exp_press));
    check("rst_release", 32'(bus.key_release), 32'(exp_release));
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_out", 32'({bus.key_level, bus.key_press, bus.key_release}), 32'(0));
    end
    reset_n = 1'b1;
  endtask

  int fall_edge;
  int exp_edges[$];
  int rem[N];

  initial begin
    bus.key_n = '1;
    reset_n   = 1'b0;
    model_reset();
    @(negedge clk);
    pulse_reset(3);
    clear_obs();
    ticks(5);

    // Clean press then release on key 0.
    clear_obs();
    bus.key_n[0] = 1'b0;
    ticks(30);
    check("clean_press_edge", 32'(first_press[0]), 32'(11));
    check("clean_press_cnt",  32'(press_cnt[0]), 32'(1));
    check("clean_level_cyc",  32'(level_cnt[0]), 32'(20));
    check("clean_others",     32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'(0));
    clear_obs();
    bus.key_n[0] = 1'b1;
    ticks(20);
    check("clean_rel_edge", 32'(first_rel[0]), 32'(11));
    check("clean_rel_cnt",  32'(release_cnt[0]), 32'(1));
    check("clean_rel_lvl",  32'(bus.key_level[0]), 32'(0));

    // Bounce on key 1, no acceptance.
    clear_obs();
    for (int r = 0; r < 5; r++) begin
      bus.key_n[1] = 1'b0; ticks(3);
      bus.key_n[1] = 1'b1; ticks(2);
    end
    ticks(20);
    check("bounce_press_cnt", 32'(press_cnt[1]), 32'(0));
    check("bounce_level_cyc", 32'(level_cnt[1]), 32'(0));

    // Bounce followed by a sustained low.
    clear_obs();
    for (int r = 0; r < 5; r++) begin
      bus.key_n[1] = 1'b0; ticks(3);
      bus.key_n[1] = 1'b1; ticks(2);
    end
    fall_edge = edge_no + 1;
    bus.key_n[1] = 1'b0;
    ticks(25);
    check("bounce_hold_cnt",  32'(press_cnt[1]), 32'(1));
    check("bounce_hold_edge", 32'(first_press[1] - fall_edge + 1), 32'(11));
    bus.key_n[1] = 1'b1;
    ticks(20);

    // All keys pressed together.
    clear_obs();
    bus.key_n = '0;
    ticks(15);
    for (int i = 0; i < N; i++) begin
      check("simul_press_edge", 32'(first_press[i]), 32'(11));
      check("simul_press_cnt",  32'(press_cnt[i]), 32'(1));
    end
    bus.key_n = '1;
    ticks(20);

    // Reset in the middle of a pending press on key 2.
    clear_obs();
    bus.key_n[2] = 1'b0;
    ticks(6);
    pulse_reset(2);
    clear_obs();
    ticks(15);
    check("rst_mid_press_edge", 32'(first_press[2]), 32'(11));
    check("rst_mid_press_cnt",  32'(press_cnt[2]), 32'(1));
    bus.key_n[2] = 1'b1;
    ticks(20);

    // Long hold on key 0: auto-repeat behaviour.
    clear_obs();
    bus.key_n[0] = 1'b0;
    ticks(60);
    bus.key_n[0] = 1'b1;
    ticks(30);
    exp_edges.delete();
    exp_edges.push_back(11);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    for (int e = 11 + int'(REP_DELAY); e <= 62; e += int'(REP_PER)) exp_edges.push_back(e);
`endif
    check("hold_press_cnt", 32'(q_press0.size()), 32'(exp_edges.size()));
    for (int k = 0; k < exp_edges.size() && k < q_press0.size(); k++)
      check("hold_press_edge", 32'(q_press0[k]), 32'(exp_edges[k]));
    check("hold_release_cnt", 32'(release_cnt[0]), 32'(1));

    // Randomized run lengths on all keys, with one reset in the middle.
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 1600; c++) begin
      for (int i = 0; i < N; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          bus.key_n[i] = ~bus.key_n[i];
          rem[i] = int'($urandom_range(1, 22));
        end
      end
      if (c == 800) pulse_reset(int'($urandom_range(1, 3)));
      tick();
    end

    bus.key_n = '1;
    ticks(25);
    check("final_level", 32'(bus.key_level), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
